// File: rtl/mem_port_sched.sv
// Arbitrates one memory beat per cycle between the MA pipeline and an aux requester; wide accesses
// take two beats (pipeline stalled on the first), read data returns one cycle after the last beat.
module mem_port_sched #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 24,
  parameter int AUX_STARVE_MAX = 8
) (
  input  logic                iw_clk,
  input  logic                iw_rst,
  input  logic                iw_pl_req,
  input  logic                iw_pl_we,
  input  logic                iw_pl_wide,
  input  logic [ADDR_W-1:0]   iw_pl_addr,
  input  logic [2*DATA_W-1:0] iw_pl_wdata,
  output logic                ow_pl_stall,
  output logic                ow_pl_rvalid,
  output logic [2*DATA_W-1:0] ow_pl_rdata,
  input  logic                iw_ax_req,
  input  logic                iw_ax_we,
  input  logic [ADDR_W-1:0]   iw_ax_addr,
  input  logic [DATA_W-1:0]   iw_ax_wdata,
  output logic                ow_ax_gnt,
  output logic                ow_ax_rvalid,
  output logic [DATA_W-1:0]   ow_ax_rdata,
  output logic                ow_mem_mp,
  output logic                ow_mem_en,
  output logic                ow_mem_we,
  output logic [ADDR_W-1:0]   ow_mem_addr,
  output logic [DATA_W-1:0]   ow_mem_wdata,
  input  logic [DATA_W-1:0]   iw_mem_rdata
);

  localparam int SW = $clog2(AUX_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(AUX_STARVE_MAX);

  typedef enum logic {S_IDLE, S_WIDE2} state_t;

  state_t            r_state, w_state_nxt;
  logic [SW-1:0]     r_starve, w_starve_nxt;
  logic              r_mp, r_pl_pend, r_wide_pend, r_ax_pend;
  logic [DATA_W-1:0] r_lo;

  logic              w_hi, w_sel_ax, w_sel_pl;
  logic              w_en, w_we, w_stall, w_gnt;
  logic              w_pl_rd, w_wide_rd, w_ax_rd;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  always_comb begin
    w_state_nxt = r_state;
    w_hi        = 1'b0;
    w_sel_ax    = 1'b0;
    w_sel_pl    = 1'b0;
    w_en        = 1'b0;
    w_we        = 1'b0;
    w_stall     = 1'b0;
    w_gnt       = 1'b0;
    w_pl_rd     = 1'b0;
    w_wide_rd   = 1'b0;
    w_ax_rd     = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    if (!iw_rst) begin
      // High beat of a wide access is never pre-empted; otherwise a starved aux beats the pipeline.
      case (r_state)
        S_WIDE2: w_hi = 1'b1;
        default: begin
          if (iw_ax_req && (r_starve == STARVE_SAT)) w_sel_ax = 1'b1;
          else if (iw_pl_req)                         w_sel_pl = 1'b1;
          else if (iw_ax_req)                         w_sel_ax = 1'b1;
        end
      endcase
      if (w_hi) begin
        w_en        = 1'b1;
        w_we        = iw_pl_we;
        w_addr      = iw_pl_addr + ADDR_W'(1);
        w_wdata     = iw_pl_we ? iw_pl_wdata[2*DATA_W-1:DATA_W] : '0;
        w_wide_rd   = !iw_pl_we;
        w_state_nxt = S_IDLE;
      end else if (w_sel_ax) begin
        w_en    = 1'b1;
        w_we    = iw_ax_we;
        w_addr  = iw_ax_addr;
        w_wdata = iw_ax_we ? iw_ax_wdata : '0;
        w_gnt   = 1'b1;
        w_stall = iw_pl_req;
        w_ax_rd = !iw_ax_we;
      end else if (w_sel_pl) begin
        w_en    = 1'b1;
        w_we    = iw_pl_we;
        w_addr  = iw_pl_addr;
        w_wdata = iw_pl_we ? iw_pl_wdata[DATA_W-1:0] : '0;
        if (iw_pl_wide) begin
          w_stall     = 1'b1;
          w_state_nxt = S_WIDE2;
        end else begin
          w_pl_rd = !iw_pl_we;
        end
      end
    end
  end

  always_comb begin
    w_starve_nxt = '0;
    if (iw_ax_req && !w_gnt)
      w_starve_nxt = (r_starve == STARVE_SAT) ? r_starve : r_starve + SW'(1);
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_state     <= S_IDLE;
      r_starve    <= '0;
      r_mp        <= 1'b0;
      r_pl_pend   <= 1'b0;
      r_wide_pend <= 1'b0;
      r_ax_pend   <= 1'b0;
      r_lo        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_starve    <= w_starve_nxt;
      r_mp        <= ~r_mp;
      r_pl_pend   <= w_pl_rd;
      r_wide_pend <= w_wide_rd;
      r_ax_pend   <= w_ax_rd;
      // The low word of a wide read arrives while its high beat is being issued.
      if (w_wide_rd) r_lo <= iw_mem_rdata;
    end
  end

  always_comb begin
    ow_pl_rdata = '0;
    if (!iw_rst) begin
      if (r_wide_pend)    ow_pl_rdata = {iw_mem_rdata, r_lo};
      else if (r_pl_pend) ow_pl_rdata = {DATA_W'(0), iw_mem_rdata};
    end
  end

  assign ow_pl_stall  = w_stall;
  assign ow_pl_rvalid = !iw_rst && (r_pl_pend || r_wide_pend);
  assign ow_ax_gnt    = w_gnt;
  assign ow_ax_rvalid = !iw_rst && r_ax_pend;
  assign ow_ax_rdata  = ow_ax_rvalid ? iw_mem_rdata : '0;
  assign ow_mem_mp    = r_mp && !iw_rst;
  assign ow_mem_en    = w_en;
  assign ow_mem_we    = w_we;
  assign ow_mem_addr  = w_addr;
  assign ow_mem_wdata = w_wdata;

endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: vector table, directed corner sequences, then random traffic vs a reference model.
module tb_mem_port_sched;

  localparam int AW   = 24;
  localparam int DW   = 24;
  localparam int SMAX = 8;

  logic          clk;
  logic          rst;
  logic          pl_req, pl_we, pl_wide;
  logic [AW-1:0] pl_addr;
  logic [47:0]   pl_wdata;
  logic          pl_stall, pl_rvalid;
  logic [47:0]   pl_rdata;
  logic          ax_req, ax_we;
  logic [AW-1:0] ax_addr;
  logic [DW-1:0] ax_wdata;
  logic          ax_gnt, ax_rvalid;
  logic [DW-1:0] ax_rdata;
  logic          mem_mp, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  mem_port_sched #(.ADDR_W(AW), .DATA_W(DW), .AUX_STARVE_MAX(SMAX)) dut (
    .iw_clk(clk), .iw_rst(rst),
    .iw_pl_req(pl_req), .iw_pl_we(pl_we), .iw_pl_wide(pl_wide),
    .iw_pl_addr(pl_addr), .iw_pl_wdata(pl_wdata),
    .ow_pl_stall(pl_stall), .ow_pl_rvalid(pl_rvalid), .ow_pl_rdata(pl_rdata),
    .iw_ax_req(ax_req), .iw_ax_we(ax_we), .iw_ax_addr(ax_addr), .iw_ax_wdata(ax_wdata),
    .ow_ax_gnt(ax_gnt), .ow_ax_rvalid(ax_rvalid), .ow_ax_rdata(ax_rdata),
    .ow_mem_mp(mem_mp), .ow_mem_en(mem_en), .ow_mem_we(mem_we),
    .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata), .iw_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content: unwritten words hold a fixed address pattern.
  logic [DW-1:0] tb_mem  [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return (a * 24'd13) ^ 24'h5A5A5A;
  endfunction
  function automatic logic [DW-1:0] tb_rd(input logic [AW-1:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : dflt(a);
  endfunction
  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Memory macro: 1-cycle read latency, garbage on the bus when no read was issued.
  always @(posedge clk) begin
    if (mem_en && mem_we) tb_mem[mem_addr] = mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= tb_rd(mem_addr);
    else                   mem_rdata <= DW'($urandom);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pl_req = 1'b0; pl_we = 1'b0; pl_wide = 1'b0; pl_addr = '0; pl_wdata = '0;
    ax_req = 1'b0; ax_we = 1'b0; ax_addr = '0; ax_wdata = '0;
  endtask

  task automatic set_pl(input logic req, input logic we, input logic wide,
                        input logic [AW-1:0] a, input logic [47:0] d);
    pl_req = req; pl_we = we; pl_wide = wide; pl_addr = a; pl_wdata = d;
  endtask

  // ---------------- single-cycle vector table ----------------
  typedef struct {
    logic          pl_req, pl_we, pl_wide;
    logic [AW-1:0] pl_addr;
    logic [47:0]   pl_wdata;
    logic          ax_req, ax_we;
    logic [AW-1:0] ax_addr;
    logic [DW-1:0] ax_wdata;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_stall, e_gnt;
  } vec_t;
  vec_t tbl [8];

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic        aux;
    logic [47:0] d;
  } ret_t;
  ret_t exp_q [$];
  logic hi_due;
  int   wait_c, free_c;
  logic          m_en, m_we, m_stall, m_gnt, m_mp, m_prv, m_arv;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_ard;
  logic [47:0]   m_prd;

  task automatic model_step(input int cyc);
    logic [AW-1:0] a1;
    ret_t r;
    m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_stall = 1'b0; m_gnt = 1'b0;
    m_mp = 1'b0; m_prv = 1'b0; m_prd = '0; m_arv = 1'b0; m_ard = '0;
    if (rst) begin
      exp_q.delete(); hi_due = 1'b0; wait_c = 0; free_c = 0;
      return;
    end
    m_mp = free_c[0];
    free_c++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      if (exp_q[0].aux) begin m_arv = 1'b1; m_ard = exp_q[0].d[DW-1:0]; end
      else              begin m_prv = 1'b1; m_prd = exp_q[0].d; end
      void'(exp_q.pop_front());
    end
    r.due = cyc + 1;
    if (hi_due) begin
      a1 = pl_addr + 24'd1;
      hi_due = 1'b0; m_en = 1'b1; m_we = pl_we; m_addr = a1;
      if (pl_we) begin m_wdata = pl_wdata[47:24]; ref_mem[a1] = m_wdata; end
      else begin r.aux = 1'b0; r.d = {ref_rd(a1), ref_rd(pl_addr)}; exp_q.push_back(r); end
    end else if (ax_req && (wait_c >= SMAX || !pl_req)) begin
      m_en = 1'b1; m_we = ax_we; m_addr = ax_addr; m_gnt = 1'b1; m_stall = pl_req;
      if (ax_we) begin m_wdata = ax_wdata; ref_mem[ax_addr] = ax_wdata; end
      else begin r.aux = 1'b1; r.d = {24'h0, ref_rd(ax_addr)}; exp_q.push_back(r); end
    end else if (pl_req) begin
      m_en = 1'b1; m_we = pl_we; m_addr = pl_addr;
      if (pl_we) begin m_wdata = pl_wdata[23:0]; ref_mem[pl_addr] = m_wdata; end
      if (pl_wide) begin m_stall = 1'b1; hi_due = 1'b1; end
      else if (!pl_we) begin r.aux = 1'b0; r.d = {24'h0, ref_rd(pl_addr)}; exp_q.push_back(r); end
    end
    wait_c = (ax_req && !m_gnt) ? ((wait_c < SMAX) ? wait_c + 1 : SMAX) : 0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFFFE;
      default: return 24'($urandom_range(0, 7));
    endcase
  endfunction

  logic hold_pl, hold_ax;
  logic [63:0] r64;

  initial begin
    tbl[0] = '{1'b0,1'b0,1'b0,24'h0,48'h0,             1'b0,1'b0,24'h0,24'h0,     1'b0,1'b0,24'h0,24'h0,1'b0,1'b0};
    tbl[1] = '{1'b1,1'b0,1'b0,24'h10,48'h0,            1'b0,1'b0,24'h0,24'h0,     1'b1,1'b0,24'h10,24'h0,1'b0,1'b0};
    tbl[2] = '{1'b1,1'b1,1'b0,24'h33,48'hFFFFFF_111111, 1'b0,1'b0,24'h0,24'h0,    1'b1,1'b1,24'h33,24'h111111,1'b0,1'b0};
    tbl[3] = '{1'b1,1'b0,1'b1,24'hFFFFFF,48'h0,        1'b0,1'b0,24'h0,24'h0,     1'b1,1'b0,24'hFFFFFF,24'h0,1'b1,1'b0};
    tbl[4] = '{1'b1,1'b1,1'b1,24'h20,48'h123456_789ABC, 1'b0,1'b0,24'h0,24'h0,    1'b1,1'b1,24'h20,24'h789ABC,1'b1,1'b0};
    tbl[5] = '{1'b0,1'b0,1'b0,24'h0,48'h0,             1'b1,1'b0,24'h44,24'h0,    1'b1,1'b0,24'h44,24'h0,1'b0,1'b1};
    tbl[6] = '{1'b0,1'b0,1'b0,24'h0,48'h0,             1'b1,1'b1,24'h55,24'hC0FFEE, 1'b1,1'b1,24'h55,24'hC0FFEE,1'b0,1'b1};
    tbl[7] = '{1'b1,1'b1,1'b0,24'h66,48'h0_AAAAAA,     1'b1,1'b0,24'h77,24'h0,    1'b1,1'b1,24'h66,24'hAAAAAA,1'b0,1'b0};

    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("reset ctrl", {mem_en, mem_we, pl_stall, ax_gnt, pl_rvalid, ax_rvalid, mem_mp}, 64'h0);
    repeat (3) to_next();
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      set_pl(tbl[v].pl_req, tbl[v].pl_we, tbl[v].pl_wide, tbl[v].pl_addr, tbl[v].pl_wdata);
      ax_req = tbl[v].ax_req; ax_we = tbl[v].ax_we; ax_addr = tbl[v].ax_addr; ax_wdata = tbl[v].ax_wdata;
      @(negedge clk);
      chk($sformatf("vec%0d en", v), mem_en, tbl[v].e_en);
      chk($sformatf("vec%0d stall", v), pl_stall, tbl[v].e_stall);
      chk($sformatf("vec%0d gnt", v), ax_gnt, tbl[v].e_gnt);
      if (tbl[v].e_en) begin
        chk($sformatf("vec%0d addr", v), mem_addr, tbl[v].e_addr);
        chk($sformatf("vec%0d we", v), mem_we, tbl[v].e_we);
        if (tbl[v].e_we) chk($sformatf("vec%0d wdata", v), mem_wdata, tbl[v].e_wdata);
      end
      to_next();
      if (tbl[v].e_stall) to_next();
      idle_inputs();
      to_next();
    end

    // Narrow read returns the word one cycle after its beat, upper half zero.
    tb_mem[24'h10] = 24'hABCDEF;
    set_pl(1'b1, 1'b0, 1'b0, 24'h10, 48'h0);
    @(negedge clk);
    chk("narrow en", mem_en, 1'b1);
    chk("narrow addr", mem_addr, 24'h10);
    chk("narrow stall", pl_stall, 1'b0);
    to_next(); pl_req = 1'b0;
    @(negedge clk);
    chk("narrow rvalid", pl_rvalid, 1'b1);
    chk("narrow rdata", pl_rdata, 48'h000000ABCDEF);
    to_next();

    // Wide read wrapping the address space.
    tb_mem[24'hFFFFFF] = 24'h111111; tb_mem[24'h0] = 24'h222222;
    set_pl(1'b1, 1'b0, 1'b1, 24'hFFFFFF, 48'h0);
    @(negedge clk);
    chk("wide rd lo addr", mem_addr, 24'hFFFFFF);
    chk("wide rd lo stall", pl_stall, 1'b1);
    to_next();
    @(negedge clk);
    chk("wide rd hi addr", mem_addr, 24'h000000);
    chk("wide rd hi stall", pl_stall, 1'b0);
    chk("wide rd early rvalid", pl_rvalid, 1'b0);
    to_next(); pl_req = 1'b0;
    @(negedge clk);
    chk("wide rd rvalid", pl_rvalid, 1'b1);
    chk("wide rd rdata", pl_rdata, 48'h222222_111111);
    to_next();

    // Wide write: low half first, high half to addr+1, no read return.
    set_pl(1'b1, 1'b1, 1'b1, 24'h20, 48'h123456_789ABC);
    @(negedge clk);
    chk("wide wr lo", {mem_we, mem_addr, mem_wdata}, {1'b1, 24'h20, 24'h789ABC});
    to_next();
    @(negedge clk);
    chk("wide wr hi", {mem_we, mem_addr, mem_wdata}, {1'b1, 24'h21, 24'h123456});
    chk("wide wr rvalid hi", pl_rvalid, 1'b0);
    to_next(); pl_req = 1'b0;
    @(negedge clk);
    chk("wide wr rvalid after", pl_rvalid, 1'b0);
    chk("wide wr mem", {tb_rd(24'h20), tb_rd(24'h21)}, {24'h789ABC, 24'h123456});
    to_next();

    // Aux starved by continuous narrow traffic is forced after SMAX waiting cycles.
    set_pl(1'b1, 1'b0, 1'b0, 24'h3, 48'h0);
    ax_req = 1'b1; ax_we = 1'b0; ax_addr = 24'h77;
    for (int k = 0; k <= SMAX; k++) begin
      @(negedge clk);
      chk($sformatf("starve gnt c%0d", k), ax_gnt, (k == SMAX));
      chk($sformatf("starve stall c%0d", k), pl_stall, (k == SMAX));
      to_next();
    end
    ax_req = 1'b0;
    @(negedge clk);
    chk("forced aux rvalid", ax_rvalid, 1'b1);
    chk("forced aux rdata", ax_rdata, tb_rd(24'h77));
    to_next();
    idle_inputs(); to_next();

    // Saturated starve during the high beat: high beat first, aux granted next cycle.
    set_pl(1'b1, 1'b0, 1'b0, 24'h3, 48'h0);
    ax_req = 1'b1; ax_we = 1'b1; ax_addr = 24'h99; ax_wdata = 24'h0D0D0D;
    for (int k = 0; k < SMAX - 1; k++) begin
      @(negedge clk);
      chk($sformatf("pre-wide gnt c%0d", k), ax_gnt, 1'b0);
      to_next();
    end
    set_pl(1'b1, 1'b0, 1'b1, 24'h40, 48'h0);
    @(negedge clk);
    chk("w2 lo", {ax_gnt, pl_stall, mem_addr}, {1'b0, 1'b1, 24'h40});
    to_next();
    @(negedge clk);
    chk("w2 hi not preempted", {ax_gnt, pl_stall, mem_addr}, {1'b0, 1'b0, 24'h41});
    to_next();
    set_pl(1'b1, 1'b0, 1'b0, 24'h5, 48'h0);
    @(negedge clk);
    chk("w2 aux after", {ax_gnt, pl_stall, mem_we, mem_addr}, {1'b1, 1'b1, 1'b1, 24'h99});
    to_next(); ax_req = 1'b0;
    to_next(); idle_inputs(); to_next();

    // Reset in the middle of a wide read aborts it.
    set_pl(1'b1, 1'b0, 1'b1, 24'h50, 48'h0);
    @(negedge clk);
    chk("rst-mid lo stall", pl_stall, 1'b1);
    to_next();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst-mid ctrl c%0d", k), {mem_en, mem_we, pl_stall, ax_gnt, pl_rvalid, ax_rvalid, mem_mp}, 64'h0);
      chk($sformatf("rst-mid data c%0d", k), {mem_addr, mem_wdata}, 64'h0);
      chk($sformatf("rst-mid rdata c%0d", k), {pl_rdata, ax_rdata}, 64'h0);
      to_next();
    end
    rst = 1'b0; idle_inputs();
    @(negedge clk);
    chk("post-rst c0", {mem_mp, pl_rvalid, mem_en}, 3'b000);
    to_next();
    @(negedge clk);
    chk("post-rst c1", {mem_mp, pl_rvalid, mem_en}, 3'b100);
    to_next();

    // Random traffic against the reference model.
    tb_mem.delete(); ref_mem.delete();
    hold_pl = 1'b0; hold_ax = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      rst = (i < 2) || ($urandom_range(0, 249) == 0);
      if (!hold_pl) begin
        r64 = {$urandom(), $urandom()};
        set_pl($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), r64[47:0]);
      end
      if (!hold_ax) begin
        ax_req = $urandom_range(0, 9) < 4; ax_we = 1'($urandom_range(0, 1));
        ax_addr = rand_addr(); ax_wdata = DW'($urandom);
      end
      model_step(i);
      @(negedge clk);
      chk("rnd en", mem_en, m_en);
      chk("rnd stall", pl_stall, m_stall);
      chk("rnd gnt", ax_gnt, m_gnt);
      chk("rnd mp", mem_mp, m_mp);
      chk("rnd pl_rvalid", pl_rvalid, m_prv);
      chk("rnd ax_rvalid", ax_rvalid, m_arv);
      if (m_en) chk("rnd addr/we", {mem_we, mem_addr}, {m_we, m_addr});
      if (m_en && m_we) chk("rnd wdata", mem_wdata, m_wdata);
      if (m_prv) chk("rnd pl_rdata", pl_rdata, m_prd);
      if (m_arv) chk("rnd ax_rdata", ax_rdata, m_ard);
      hold_pl = m_stall;
      hold_ax = ax_req && !m_gnt;
      to_next();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
